// File: rtl/bus_pkg.sv
// Shared constants and helpers for the round-robin bus and its per-client queues.
package bus_pkg;

  // Default message width and number of client slots on the shared bus.
  localparam int BUS_WIDTH   = 2;
  localparam int BUS_CLIENTS = 4;

  // One bus message at the default width.
  typedef logic [BUS_WIDTH-1:0] msg_t;

  // Occupancy must represent 0..depth inclusive, so it needs one bit more than a pointer.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/bus_fifo_mem.sv
// DEPTH x WIDTH register file: one synchronous write port, one asynchronous read port.
module bus_fifo_mem #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  // Storage holds no reset value; entries are only read once they have been written.
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write the producer's word at the write address.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // The head is read combinationally so the queue can fall through in one cycle.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/bus_tx_queue.sv
// Per-client transmit FIFO in front of the shared round-robin bus.
// The head entry is offered to the bus as (bus_message, bus_write) and retired on bus_sent.
module bus_tx_queue
  import bus_pkg::*;
#(
  parameter int WIDTH     = BUS_WIDTH,
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [WIDTH-1:0]              in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [WIDTH-1:0]              bus_message,
  output logic                          bus_write,
  input  logic                          bus_sent,
  output logic [level_width(DEPTH)-1:0] level,
  output logic [CNT_WIDTH-1:0]          sent_count,
  output logic                          err_spurious
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = level_width(DEPTH);

  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]        level_q, level_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 err_q, err_d;

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] head_data;

  // Full and empty come from the occupancy count; pointers alone cannot tell them apart.
  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);

  // A full queue refuses the producer even if the head retires this same cycle.
  assign push = in_valid && !full;
  assign pop  = bus_sent && !empty;

  bus_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clock),
    .we_i    (push && !reset),
    .waddr_i (wr_ptr_q),
    .wdata_i (in_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (head_data)
  );

  // Next-state for pointers, occupancy, retire counter and the sticky error flag.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    cnt_d    = cnt_q;
    err_d    = err_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      cnt_d    = cnt_q + CNT_WIDTH'(1);
    end

    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    // A sent pulse with nothing queued means the bus and this slot disagree.
    if (bus_sent && empty) begin
      err_d = 1'b1;
    end
  end

  // State register; reset wins over any push or pop in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  // Bus-facing outputs depend only on registered state; zero when empty keeps X off the bus.
  assign bus_write    = !empty;
  assign bus_message  = empty ? '0 : head_data;
  assign in_ready     = !full;
  assign level        = level_q;
  assign sent_count   = cnt_q;
  assign err_spurious = err_q;

endmodule

// File: tb/tb_bus_tx_queue.sv
// Scoreboard bench for bus_tx_queue: a queue-based reference model tracks every
// accepted message, and a negedge monitor compares outputs and retired messages.
module tb_bus_tx_queue;
  import bus_pkg::*;

  localparam int WIDTH     = BUS_WIDTH;
  localparam int DEPTH     = 4;
  localparam int CNT_WIDTH = 16;
  localparam int LW        = level_width(DEPTH);

  logic                 clock = 1'b0;
  logic                 reset;
  msg_t                 in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     bus_message;
  logic                 bus_write;
  logic                 bus_sent;
  logic [LW-1:0]        level;
  logic [CNT_WIDTH-1:0] sent_count;
  logic                 err_spurious;

  bus_tx_queue #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .bus_message  (bus_message),
    .bus_write    (bus_write),
    .bus_sent     (bus_sent),
    .level        (level),
    .sent_count   (sent_count),
    .err_spurious (err_spurious)
  );

  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: a plain queue of accepted messages plus counters.
  msg_t        exp_q[$];
  int          m_level = 0;
  int unsigned m_cnt   = 0;
  bit          m_err   = 1'b0;
  bit          started = 1'b0;
  bit          do_push;
  bit          do_pop;
  msg_t        exp_head;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, req, $time);
    end
  endtask

  // Model update at each rising edge from the inputs the DUT samples there.
  always @(posedge clock) begin
    if (reset) begin
      m_level = 0;
      m_cnt   = 0;
      m_err   = 1'b0;
      exp_q.delete();
    end else begin
      do_pop  = bus_sent && (m_level != 0);
      do_push = in_valid && (m_level < DEPTH);
      if (bus_sent && m_level == 0) m_err = 1'b1;
      if (do_pop) begin
        m_level--;
        m_cnt = (m_cnt + 1) % (1 << CNT_WIDTH);
      end
      if (do_push) begin
        m_level++;
        exp_q.push_back(in_data);
      end
    end
  end

  // Monitor: compare status every cycle; pop the scoreboard when the head retires.
  always @(negedge clock) begin
    if (started) begin
      check("level", 32'(level), 32'(m_level));
      check("in_ready", 32'(in_ready), 32'(m_level < DEPTH));
      check("bus_write", 32'(bus_write), 32'(m_level != 0));
      check("sent_count", 32'(sent_count), 32'(m_cnt));
      check("err_spurious", 32'(err_spurious), 32'(m_err));
      if (m_level == 0) begin
        check("msg_known", 32'($isunknown(bus_message)), 32'(0));
      end else begin
        check("bus_message", 32'(bus_message), 32'(exp_q[0]));
        if (!reset && bus_sent) begin
          exp_head = exp_q.pop_front();
          $display("retire #%0d msg=%0h level=%0d", m_cnt + 1, exp_head, m_level);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  bit pending;
  bit accepted;

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    bus_sent = 1'b0;
    tick();
    started = 1'b1;
    tick();
    reset = 1'b0;

    // Idle after reset.
    repeat (3) tick();

    // Three pushes, then three spaced retires.
    for (int v = 1; v <= 3; v++) begin
      in_valid = 1'b1;
      in_data  = msg_t'(v);
      tick();
    end
    in_valid = 1'b0;
    tick();
    repeat (3) begin
      bus_sent = 1'b1;
      tick();
      bus_sent = 1'b0;
      tick();
      tick();
    end

    // Fill to DEPTH, then offer a word together with a retire while full.
    for (int v = 0; v < DEPTH; v++) begin
      in_valid = 1'b1;
      in_data  = msg_t'(v);
      tick();
    end
    in_valid = 1'b0;
    tick();
    in_valid = 1'b1;
    in_data  = msg_t'(2);
    bus_sent = 1'b1;
    tick();
    bus_sent = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    bus_sent = 1'b1;
    repeat (DEPTH) tick();
    bus_sent = 1'b0;
    tick();

    // Pointer wrap: level held at 2 while push and pop run together.
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_data = msg_t'(i + 1);
      tick();
    end
    bus_sent = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = msg_t'(i);
      tick();
    end
    in_valid = 1'b0;
    repeat (2) tick();
    bus_sent = 1'b0;
    tick();

    // Spurious sent while empty, then clear by reset.
    bus_sent = 1'b1;
    tick();
    bus_sent = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();

    // Reset with entries queued and a push and retire pending.
    for (int v = 1; v <= 3; v++) begin
      in_valid = 1'b1;
      in_data  = msg_t'(v);
      tick();
    end
    in_data  = msg_t'(3);
    bus_sent = 1'b1;
    reset    = 1'b1;
    tick();
    reset    = 1'b0;
    in_valid = 1'b0;
    bus_sent = 1'b0;
    repeat (2) tick();

    // Random traffic; the producer holds its offer until accepted.
    accepted = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      if (!in_valid || accepted) begin
        in_valid = ($urandom_range(0, 99) < 60);
        in_data  = msg_t'($urandom);
      end
      bus_sent = ($urandom_range(0, 99) < 45);
      reset    = ($urandom_range(0, 199) == 0);
      accepted = in_valid && in_ready;
      tick();
    end
    reset    = 1'b0;
    bus_sent = 1'b0;
    in_valid = 1'b0;
    reset    = 1'b1;
    tick();
    reset = 1'b0;

    // Bus-like coupling: the slot is polled every BUS_CLIENTS cycles and sent follows one cycle later.
    pending  = 1'b0;
    accepted = 1'b1;
    for (int c = 0; c < 1200; c++) begin
      if (!in_valid || accepted) begin
        in_valid = ($urandom_range(0, 99) < 30);
        in_data  = msg_t'($urandom);
      end
      bus_sent = pending;
      pending  = ((c % BUS_CLIENTS) == 0) && bus_write;
      accepted = in_valid && in_ready;
      tick();
    end
    in_valid = 1'b0;
    bus_sent = 1'b0;
    repeat (3) tick();

    @(negedge clock);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bus_tx_queue.md
Name: bus_tx_queue

Overview:
Per-client transmit queue sitting directly upstream of the round-robin shared bus, one instance per client slot.
- Buffers messages from a local producer in a FIFO.
- Presents the head entry to the bus as a (message, write) pair.
- Retires the head when the bus reports it was sent.
- Provides occupancy, a sent-message counter and a sticky protocol-error flag.

Parameters:
WIDTH, 2, message width in bits; must match the bus WIDTH.
DEPTH, 4, FIFO entries; power of two, >= 2.
CNT_WIDTH, 16, width of the sent-message counter.

Ports:
clock  input  1  single clock; all state updates on its rising edge.
reset  input  1  synchronous, active-high reset.
in_data  input  WIDTH  message from the local producer.
in_valid  input  1  producer offers in_data this cycle.
in_ready  output  1  queue accepts in_data this cycle; equals not full.
bus_message  output  WIDTH  head entry; drives the bus messages[i] slot.
bus_write  output  1  queue non-empty; drives the bus write[i] slot.
bus_sent  input  1  bus sent[i] for this slot; head was transferred.
level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
sent_count  output  CNT_WIDTH  number of messages retired since reset; wraps.
err_spurious  output  1  sticky flag: bus_sent seen while the queue was empty.

Behaviour:
- Reset (reset=1 at an edge):
  - Read pointer, write pointer and level go to 0.
  - sent_count goes to 0; err_spurious goes to 0.
  - Storage contents are don't-care.
  - After reset: bus_write=0, in_ready=1, level=0.
  - Reset has priority over a push or pop in the same cycle.
  - Mid-operation reset discards all queued entries.
- Push: occurs at an edge when in_valid && in_ready. in_data is written at the write pointer, which increments modulo DEPTH.
- Pop: occurs at an edge when bus_sent && level!=0. The read pointer increments modulo DEPTH and sent_count increments, wrapping at 2^CNT_WIDTH.
- Level update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged; both pointers advance.
- Full: in_ready=0 when level==DEPTH. A push is not accepted even if a pop occurs in the same cycle. The producer holds in_data/in_valid until accepted.
- Empty:
  - bus_write=0 when level==0.
  - bus_message is don't-care when empty, but must not be X in simulation; drive the stored word or 0.
- Spurious sent: bus_sent=1 with level==0 at an edge sets err_spurious=1. No pop occurs, sent_count is unchanged and level stays 0. The flag clears only on reset.
- Latency:
  - First-word fall-through: a push at edge k gives bus_write=1 and bus_message=in_data from edge k (visible in cycle k+1).
  - A pop at edge k presents the next entry, or bus_write=0, from edge k.
- Bus coupling: the bus asserts sent one cycle after sampling write. The head is therefore still offered during that gap; this is correct because the arbiter has moved on. For CLIENTS>=2, the head has advanced before this slot is polled again.
- bus_message and bus_write are combinational from registered state only: storage read at the read pointer, and the level compare. They have no path from bus_sent or in_valid.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty is derived from level, not pointer compare.

Decomposition:
- Shared package bus_pkg:
  - default WIDTH and CLIENTS constants
  - typedef msg_t (logic [WIDTH-1:0])
  - helper function for level width
- One natural sub-module, bus_fifo_mem: DEPTH x WIDTH register file with one write port and an asynchronous read port at an address. Pointers, level, counter and flags stay in bus_tx_queue.

Test Plan:
1. Reset, then idle 3 cycles -> bus_write=0, in_ready=1, level=0, sent_count=0, err_spurious=0.
2. Push 0x1, 0x2, 0x3 on consecutive cycles -> level=1,2,3; bus_message=0x1 with bus_write=1 from the cycle after the first push. Pulse bus_sent 3 times with gaps -> bus_message shows 0x2, then 0x3, then bus_write=0; sent_count=3.
3. Fill 4 entries (DEPTH=4) -> in_ready=0, level=4. Assert in_valid with 0x2 plus bus_sent in the same cycle -> pop only, level=3, 0x2 not accepted. Next cycle the push is accepted -> level=4.
4. Pointer wrap: push/pop 10 messages with level kept at 2 via simultaneous push+pop -> bus_message order exactly matches push order; sent_count=10.
5. bus_sent=1 while empty -> err_spurious=1 and stays 1; level=0; sent_count unchanged. Reset clears it.
6. Reset asserted with level=3 while in_valid=1 and bus_sent=1 -> after the edge, level=0, bus_write=0, sent_count=0, and no entry is written. Connect 4 instances to the bus with CLIENTS=4 -> every pushed message appears on the bus message output exactly once, in per-client order.
